// File: rtl/order_request_issuer.sv
// Order request issuer: buffers parsed order requests in a FIFO and issues them one at a time to order_book_wrapper.
// Optional WAIT_DONE watchdog enabled by defining ISSUE_TIMEOUT_EN.
package order_book_pkg;
  localparam int unsigned STOCK_INDEX    = 2;
  localparam int unsigned NUM_STOCKS     = 4;
  localparam int unsigned PRICE_INDEX    = 15;
  localparam int unsigned ORDER_INDEX    = 7;
  localparam int unsigned QUANTITY_INDEX = 7;

  localparam logic [2:0] NO_REQUEST   = 3'd0;
  localparam logic [2:0] ADD_ORDER    = 3'd1;
  localparam logic [2:0] CANCEL_ORDER = 3'd2;
  localparam logic [2:0] TRADE_ORDER  = 3'd3;

  typedef struct packed {
    logic [PRICE_INDEX:0]    price;
    logic [ORDER_INDEX:0]    order_id;
    logic [QUANTITY_INDEX:0] quantity;
  } book_entry;
endpackage

module order_request_issuer
  import order_book_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [STOCK_INDEX:0]          in_stock,
  input  book_entry                     in_entry,
  input  logic [2:0]                    in_request,
  input  logic [ORDER_INDEX:0]          in_order_id,
  input  logic [QUANTITY_INDEX:0]       in_quantity,
  input  logic                          in_delete,
  output logic [STOCK_INDEX:0]          stock_to_add,
  output book_entry                     order_to_add,
  output logic                          start,
  output logic [2:0]                    request,
  output logic [ORDER_INDEX:0]          order_id,
  output logic                          delete,
  output logic [QUANTITY_INDEX:0]       quantity,
  input  logic                          is_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              issued_count,
  output logic [CNT_W-1:0]              rejected_count,
  output logic                          timeout_err,
  output logic                          idle
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("order_request_issuer: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef struct packed {
    logic [STOCK_INDEX:0]    stock;
    book_entry               entry;
    logic [2:0]              request;
    logic [ORDER_INDEX:0]    order_id;
    logic [QUANTITY_INDEX:0] quantity;
    logic                    del;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT_DONE} state_t;

  req_t                    mem_q [FIFO_DEPTH];
  req_t                    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]          count_q, count_d;
  state_t                  state_q, state_d;
  logic [STOCK_INDEX:0]    stock_q, stock_d;
  book_entry               entry_q, entry_d;
  logic [2:0]              request_q, request_d;
  logic [ORDER_INDEX:0]    order_id_q, order_id_d;
  logic [QUANTITY_INDEX:0] quantity_q, quantity_d;
  logic                    delete_q, delete_d;
  logic                    start_q, start_d;
  logic [CNT_W-1:0]        issued_q, issued_d, rejected_q, rejected_d;
  logic                    full, empty, push, pop;
  req_t                    head;

`ifdef ISSUE_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    stock_d    = stock_q;
    entry_d    = entry_q;
    request_d  = request_q;
    order_id_d = order_id_q;
    quantity_d = quantity_q;
    delete_d   = delete_q;
    start_d    = start_q;
    issued_d   = issued_q;
    rejected_d = rejected_q;
    pop        = 1'b0;
`ifdef ISSUE_TIMEOUT_EN
    wd_d       = '0;
    timeout_d  = timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (!empty && !is_busy) begin
          pop = 1'b1;
          if (32'(head.stock) >= NUM_STOCKS) begin
            if (~&rejected_q) rejected_d = rejected_q + CNT_W'(1);
          end else begin
            stock_d    = head.stock;
            entry_d    = head.entry;
            request_d  = head.request;
            order_id_d = head.order_id;
            quantity_d = head.quantity;
            delete_d   = head.del;
            start_d    = 1'b1;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        start_d = 1'b0;
        if (~&issued_q) issued_d = issued_q + CNT_W'(1);
        state_d = S_ARM;
      end
      S_ARM: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (!is_busy) begin
          state_d = S_IDLE;
`ifdef ISSUE_TIMEOUT_EN
        end else if (wd_q == WD_LAST) begin
          timeout_d  = 1'b1;
          state_d    = S_IDLE;
          stock_d    = '0;
          entry_d    = '0;
          request_d  = '0;
          order_id_d = '0;
          quantity_d = '0;
          delete_d   = 1'b0;
        end else begin
          wd_d = wd_q + WD_W'(1);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Push and pop in the same cycle leave the occupancy unchanged.
    if (push) begin
      mem_d[wr_ptr_q] = '{stock: in_stock, entry: in_entry, request: in_request,
                          order_id: in_order_id, quantity: in_quantity, del: in_delete};
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      stock_q    <= '0;
      entry_q    <= '0;
      request_q  <= '0;
      order_id_q <= '0;
      quantity_q <= '0;
      delete_q   <= 1'b0;
      start_q    <= 1'b0;
      issued_q   <= '0;
      rejected_q <= '0;
`ifdef ISSUE_TIMEOUT_EN
      wd_q       <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      stock_q    <= stock_d;
      entry_q    <= entry_d;
      request_q  <= request_d;
      order_id_q <= order_id_d;
      quantity_q <= quantity_d;
      delete_q   <= delete_d;
      start_q    <= start_d;
      issued_q   <= issued_d;
      rejected_q <= rejected_d;
`ifdef ISSUE_TIMEOUT_EN
      wd_q       <= wd_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

`ifdef ISSUE_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign in_ready       = !full;
  assign stock_to_add   = stock_q;
  assign order_to_add   = entry_q;
  assign start          = start_q;
  assign request        = request_q;
  assign order_id       = order_id_q;
  assign delete         = delete_q;
  assign quantity       = quantity_q;
  assign fifo_count     = count_q;
  assign issued_count   = issued_q;
  assign rejected_count = rejected_q;
  assign idle           = (state_q == S_IDLE) && empty;

endmodule

// File: tb/tb_order_request_issuer.sv
// Directed self-checking bench for order_request_issuer: reset, single add, cancel, fill,
// reject, reset mid-operation and (with ISSUE_TIMEOUT_EN) the watchdog.
module tb_order_request_issuer;
  import order_book_pkg::*;

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic                    in_valid;
  logic                    in_ready;
  logic [STOCK_INDEX:0]    in_stock;
  book_entry               in_entry;
  logic [2:0]              in_request;
  logic [ORDER_INDEX:0]    in_order_id;
  logic [QUANTITY_INDEX:0] in_quantity;
  logic                    in_delete;
  logic [STOCK_INDEX:0]    stock_to_add;
  book_entry               order_to_add;
  logic                    start;
  logic [2:0]              request;
  logic [ORDER_INDEX:0]    order_id;
  logic                    delete;
  logic [QUANTITY_INDEX:0] quantity;
  logic                    is_busy;
  logic [3:0]              fifo_count;
  logic [15:0]             issued_count;
  logic [15:0]             rejected_count;
  logic                    timeout_err;
  logic                    idle;

  int n_checks = 0;
  int n_pass   = 0;

  order_request_issuer #(
    .FIFO_DEPTH    (8),
    .CNT_W         (16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_stock      (in_stock),
    .in_entry      (in_entry),
    .in_request    (in_request),
    .in_order_id   (in_order_id),
    .in_quantity   (in_quantity),
    .in_delete     (in_delete),
    .stock_to_add  (stock_to_add),
    .order_to_add  (order_to_add),
    .start         (start),
    .request       (request),
    .order_id      (order_id),
    .delete        (delete),
    .quantity      (quantity),
    .is_busy       (is_busy),
    .fifo_count    (fifo_count),
    .issued_count  (issued_count),
    .rejected_count(rejected_count),
    .timeout_err   (timeout_err),
    .idle          (idle)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [STOCK_INDEX:0] stk, input logic [2:0] req,
                       input logic [ORDER_INDEX:0] id, input logic [QUANTITY_INDEX:0] qty,
                       input logic [PRICE_INDEX:0] price, input logic del);
    in_valid    = 1'b1;
    in_stock    = stk;
    in_request  = req;
    in_order_id = id;
    in_quantity = qty;
    in_delete   = del;
    in_entry    = '{price: price, order_id: id, quantity: qty};
  endtask

  // Ticks until start is seen high or the budget runs out; an expired budget is a failed check.
  task automatic wait_start(input string tag, input int max, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!start && cycles < max);
    check_eq(tag, 64'(start), 64'd1);
  endtask

  task automatic count_starts(input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (start) c++;
    end
  endtask

  initial begin
    int cyc;
    int c;
    rst_in = 1'b1; in_valid = 1'b0; is_busy = 1'b0;
    in_stock = '0; in_entry = '0; in_request = '0; in_order_id = '0; in_quantity = '0; in_delete = 1'b0;
    tick(); tick();
    rst_in = 1'b0;

    check_eq("rst_start", 64'(start), 64'd0);
    check_eq("rst_fifo_count", 64'(fifo_count), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_issued", 64'(issued_count), 64'd0);
    check_eq("rst_rejected", 64'(rejected_count), 64'd0);
    check_eq("rst_timeout", 64'(timeout_err), 64'd0);
    check_eq("rst_idle", 64'(idle), 64'd1);
    check_eq("rst_fields", {37'(stock_to_add), 27'(request)}, 64'd0);

    // Single ADD: push at edge t, start seen high after edge t+1.
    drive(3'd1, ADD_ORDER, 8'd2, 8'd2, 16'(100 << 8), 1'b0);
    tick();
    in_valid = 1'b0;
    check_eq("add_fifo_count", 64'(fifo_count), 64'd1);
    check_eq("add_no_early_start", 64'(start), 64'd0);
    wait_start("add_start", 4, cyc);
    check_eq("add_latency", 64'(cyc), 64'd1);
    check_eq("add_stock", 64'(stock_to_add), 64'd1);
    check_eq("add_price", 64'(order_to_add.price), 64'd25600);
    check_eq("add_qty", 64'(quantity), 64'd2);
    check_eq("add_request", 64'(request), 64'(ADD_ORDER));
    is_busy = 1'b1;
    tick();
    check_eq("add_start_one_cycle", 64'(start), 64'd0);
    check_eq("add_issued", 64'(issued_count), 64'd1);
    tick(); tick(); tick();
    check_eq("add_hold_stock", 64'(stock_to_add), 64'd1);
    check_eq("add_hold_id", 64'(order_id), 64'd2);
    check_eq("add_busy_not_idle", 64'(idle), 64'd0);
    is_busy = 1'b0;
    tick();
    check_eq("add_back_idle", 64'(idle), 64'd1);

    // Cancel: exactly one start carrying the cancel fields.
    drive(3'd2, CANCEL_ORDER, 8'd3, 8'd0, 16'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_start("cxl_start", 4, cyc);
    check_eq("cxl_request", 64'(request), 64'(CANCEL_ORDER));
    check_eq("cxl_order_id", 64'(order_id), 64'd3);
    check_eq("cxl_delete", 64'(delete), 64'd1);
    count_starts(6, c);
    check_eq("cxl_single_start", 64'(c), 64'd0);
    check_eq("cxl_issued", 64'(issued_count), 64'd2);

    // Fill: eight pushes while the wrapper is busy, then drain in order.
    is_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(3'(i % 4), ADD_ORDER, 8'(8'h10 + i), 8'(i + 1), 16'(i * 3), 1'b0);
      tick();
    end
    check_eq("fill_count", 64'(fifo_count), 64'd8);
    check_eq("fill_in_ready", 64'(in_ready), 64'd0);
    drive(3'd0, ADD_ORDER, 8'hEE, 8'd1, 16'd1, 1'b0);
    tick();
    in_valid = 1'b0;
    check_eq("fill_no_overflow", 64'(fifo_count), 64'd8);
    check_eq("fill_no_issue_busy", 64'(start), 64'd0);
    for (int i = 0; i < 8; i++) begin
      is_busy = 1'b0;
      wait_start($sformatf("fill_start%0d", i), 6, cyc);
      check_eq($sformatf("fill_gap%0d", i), 64'(cyc), (i == 0) ? 64'd1 : 64'd2);
      check_eq($sformatf("fill_id%0d", i), 64'(order_id), 64'(8'h10 + i));
      check_eq($sformatf("fill_stock%0d", i), 64'(stock_to_add), 64'(i % 4));
      is_busy = 1'b1;
      count_starts(3, c);
      check_eq($sformatf("fill_quiet%0d", i), 64'(c), 64'd0);
    end
    check_eq("fill_drained", 64'(fifo_count), 64'd0);
    check_eq("fill_issued", 64'(issued_count), 64'd10);
    is_busy = 1'b0;
    tick();

    // Reject: stock == NUM_STOCKS is dropped while the next entry is pushed.
    drive(3'(NUM_STOCKS), ADD_ORDER, 8'h44, 8'd1, 16'd5, 1'b0);
    tick();
    drive(3'd3, ADD_ORDER, 8'h55, 8'd7, 16'd9, 1'b0);
    tick();
    in_valid = 1'b0;
    check_eq("rej_push_pop_count", 64'(fifo_count), 64'd1);
    check_eq("rej_rejected", 64'(rejected_count), 64'd1);
    check_eq("rej_no_start", 64'(start), 64'd0);
    wait_start("rej_next_start", 4, cyc);
    check_eq("rej_next_latency", 64'(cyc), 64'd1);
    check_eq("rej_next_id", 64'(order_id), 64'h55);
    check_eq("rej_next_stock", 64'(stock_to_add), 64'd3);
    count_starts(5, c);
    check_eq("rej_issued", 64'(issued_count), 64'd11);

    // Reset in WAIT_DONE with three entries queued.
    drive(3'd0, TRADE_ORDER, 8'h21, 8'd4, 16'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    wait_start("rmo_start", 4, cyc);
    is_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'd1, ADD_ORDER, 8'(8'h30 + i), 8'd1, 16'd1, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    check_eq("rmo_queued", 64'(fifo_count), 64'd3);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check_eq("rmo_start_low", 64'(start), 64'd0);
    check_eq("rmo_fifo_count", 64'(fifo_count), 64'd0);
    check_eq("rmo_issued", 64'(issued_count), 64'd0);
    check_eq("rmo_rejected", 64'(rejected_count), 64'd0);
    check_eq("rmo_idle", 64'(idle), 64'd1);
    is_busy = 1'b0;
    count_starts(6, c);
    check_eq("rmo_discarded", 64'(c), 64'd0);

`ifdef ISSUE_TIMEOUT_EN
    // Watchdog: 16 cycles in WAIT_DONE with busy held high.
    drive(3'd2, ADD_ORDER, 8'h66, 8'd3, 16'd7, 1'b0);
    tick();
    in_valid = 1'b0;
    wait_start("wd_start", 4, cyc);
    is_busy = 1'b1;
    tick(); tick();
    for (int k = 0; k < 15; k++) tick();
    check_eq("wd_not_yet", 64'(timeout_err), 64'd0);
    tick();
    check_eq("wd_timeout", 64'(timeout_err), 64'd1);
    check_eq("wd_idle", 64'(idle), 64'd1);
    check_eq("wd_fields_cleared", 64'(stock_to_add), 64'd0);
    tick(); tick();
    check_eq("wd_sticky", 64'(timeout_err), 64'd1);
    is_busy = 1'b0;
`else
    // Without the watchdog, WAIT_DONE waits as long as busy stays high.
    drive(3'd2, ADD_ORDER, 8'h66, 8'd3, 16'd7, 1'b0);
    tick();
    in_valid = 1'b0;
    wait_start("wd_start", 4, cyc);
    is_busy = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    check_eq("nowd_timeout", 64'(timeout_err), 64'd0);
    check_eq("nowd_still_waiting", 64'(idle), 64'd0);
    is_busy = 1'b0;
    tick();
    check_eq("nowd_release", 64'(idle), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
